// File: rtl/dbus_xbar.sv
// N-master / M-slave DBus crossbar: round-robin arbiter, block address decode,
// gated slave strobes and registered read-return routing. Optional macro: DBUS_XBAR_DECODE_ERR_EN.
module dbus_xbar #(
  parameter int unsigned NUM_MASTERS         = 2,
  parameter int unsigned NUM_SLAVES          = 4,
  parameter int unsigned ADDR_BITS_PER_BLOCK = 8,
  parameter int unsigned SLAVE_BASE_BLOCK    = 0
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic [30*NUM_MASTERS-1:0] i_M_Addr,
  input  logic [NUM_MASTERS-1:0]    i_M_Re,
  input  logic [NUM_MASTERS-1:0]    i_M_We,
  input  logic [4*NUM_MASTERS-1:0]  i_M_ByteEn,
  input  logic [32*NUM_MASTERS-1:0] i_M_Wd,
  output logic [NUM_MASTERS-1:0]    o_M_Stall,
  output logic [32*NUM_MASTERS-1:0] o_M_Rd,
  output logic [NUM_MASTERS-1:0]    o_M_RdValid,
  output logic [29:0]               o_S_Addr,
  output logic [NUM_SLAVES-1:0]     o_S_Re,
  output logic [NUM_SLAVES-1:0]     o_S_We,
  output logic [3:0]                o_S_ByteEn,
  output logic [31:0]               o_S_Wd,
  input  logic [32*NUM_SLAVES-1:0]  i_S_Rd,
  output logic                      o_DecodeErr
);

  localparam int unsigned PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

`ifdef DBUS_XBAR_DECODE_ERR_EN
  localparam logic [31:0] MISS_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] MISS_DATA = '0;
`endif

  logic [NUM_MASTERS-1:0] w_Req;
  logic [NUM_MASTERS-1:0] w_Gnt;
  logic [PW-1:0]          w_GntIdx;
  logic                   w_Any;
  logic [31:0]            w_Idx;
  logic                   w_IsWr;
  logic                   w_IsRd;
  logic [29:0]            w_Addr;
  logic [31:0]            w_Block;
  logic                   w_Mapped;
  logic [SW-1:0]          w_SlvIdx;

  logic [PW-1:0]          r_RrPtr;
  logic                   r_RdPend;
  logic [PW-1:0]          r_RdMst;
  logic [SW-1:0]          r_RdSlv;
  logic                   r_RdMiss;

  assign w_Req = i_M_Re | i_M_We;

  // Scan requesters in rotation order starting at the pointer; first hit wins.
  always_comb begin
    w_Any    = 1'b0;
    w_GntIdx = '0;
    w_Idx    = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      w_Idx = 32'(r_RrPtr) + k;
      if (w_Idx >= NUM_MASTERS) w_Idx = w_Idx - NUM_MASTERS;
      if (!w_Any && w_Req[PW'(w_Idx)]) begin
        w_Any    = 1'b1;
        w_GntIdx = PW'(w_Idx);
      end
    end
    w_Gnt           = '0;
    w_Gnt[w_GntIdx] = w_Any;
  end

  assign o_M_Stall = w_Req & ~w_Gnt;
  assign w_IsWr    = w_Any & i_M_We[w_GntIdx];
  assign w_IsRd    = w_Any & ~w_IsWr;

  assign w_Addr   = w_Any ? i_M_Addr[32'(w_GntIdx)*30 +: 30] : '0;
  assign w_Block  = 32'(w_Addr[29:ADDR_BITS_PER_BLOCK]);
  assign w_Mapped = (w_Block >= SLAVE_BASE_BLOCK) && (w_Block < SLAVE_BASE_BLOCK + NUM_SLAVES);
  assign w_SlvIdx = SW'(w_Block - SLAVE_BASE_BLOCK);

  always_comb begin
    o_S_Addr   = w_Addr;
    o_S_ByteEn = w_Any ? i_M_ByteEn[32'(w_GntIdx)*4 +: 4] : '0;
    o_S_Wd     = w_Any ? i_M_Wd[32'(w_GntIdx)*32 +: 32] : '0;
    o_S_Re     = '0;
    o_S_We     = '0;
    if (w_Mapped) begin
      o_S_Re[w_SlvIdx] = w_IsRd;
      o_S_We[w_SlvIdx] = w_IsWr;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_RrPtr  <= '0;
      r_RdPend <= 1'b0;
      r_RdMst  <= '0;
      r_RdSlv  <= '0;
      r_RdMiss <= 1'b0;
    end else begin
      if (w_Any) r_RrPtr <= (32'(w_GntIdx) == NUM_MASTERS - 1) ? '0 : w_GntIdx + 1'b1;
      r_RdPend <= w_IsRd;
      if (w_IsRd) begin
        r_RdMst  <= w_GntIdx;
        r_RdSlv  <= w_SlvIdx;
        r_RdMiss <= ~w_Mapped;
      end
    end
  end

  // Slave read data is valid the cycle after the strobe, so it is steered straight through.
  always_comb begin
    o_M_RdValid = '0;
    o_M_Rd      = '0;
    if (r_RdPend) begin
      o_M_RdValid[r_RdMst]          = 1'b1;
      o_M_Rd[32'(r_RdMst)*32 +: 32] = r_RdMiss ? MISS_DATA : i_S_Rd[32'(r_RdSlv)*32 +: 32];
    end
  end

`ifdef DBUS_XBAR_DECODE_ERR_EN
  logic r_DecErr;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_DecErr <= 1'b0;
    else          r_DecErr <= w_Any & ~w_Mapped;
  end

  assign o_DecodeErr = r_DecErr;
`else
  assign o_DecodeErr = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_xbar.sv
// Self-checking bench for dbus_xbar: vector table, directed multi-cycle sequences,
// and randomized traffic against a rotation-order reference model.
module tb_dbus_xbar;
  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AB = 8;
  localparam int BASE = 0;
`ifdef DBUS_XBAR_DECODE_ERR_EN
  localparam logic [31:0] MISS = 32'hDEAD_BEEF;
  localparam bit DERR = 1'b1;
`else
  localparam logic [31:0] MISS = 32'h0;
  localparam bit DERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [30*NM-1:0] m_addr;
  logic [NM-1:0]    m_re, m_we;
  logic [4*NM-1:0]  m_be;
  logic [32*NM-1:0] m_wd;
  logic [NM-1:0]    m_stall;
  logic [32*NM-1:0] m_rd;
  logic [NM-1:0]    m_rdvalid;
  logic [29:0]      s_addr;
  logic [NS-1:0]    s_re, s_we;
  logic [3:0]       s_be;
  logic [31:0]      s_wd;
  logic [32*NS-1:0] s_rd;
  logic             derr;

  dbus_xbar #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_BITS_PER_BLOCK(AB), .SLAVE_BASE_BLOCK(BASE)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_M_Addr(m_addr), .i_M_Re(m_re), .i_M_We(m_we), .i_M_ByteEn(m_be), .i_M_Wd(m_wd),
    .o_M_Stall(m_stall), .o_M_Rd(m_rd), .o_M_RdValid(m_rdvalid),
    .o_S_Addr(s_addr), .o_S_Re(s_re), .o_S_We(s_we), .o_S_ByteEn(s_be), .o_S_Wd(s_wd),
    .i_S_Rd(s_rd), .o_DecodeErr(derr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic [29:0] a, input logic re, input logic we);
    m_addr[30*m +: 30] = a;
    m_re[m] = re;
    m_we[m] = we;
  endtask

  task automatic idle();
    m_addr = '0;
    m_re   = '0;
    m_we   = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [29:0] a0; logic re0; logic we0;
    logic [29:0] a1; logic re1; logic we1;
    logic [3:0]  sre; logic [3:0] swe; logic [29:0] saddr;
    logic [3:0]  sbe; logic [31:0] swd; logic [1:0] stall;
  } vec_t;

  vec_t tbl[8];

  // reference model state
  int ptr, pm, ps, gm, blk, idx;
  bit pend, pmiss, derr_q, mapped;
  logic [NM-1:0]    req, gnt, exp_v;
  logic [NS-1:0]    exp_sre, exp_swe;
  logic [63:0]      exp_rd;
  logic [29:0]      a, exp_addr;
  logic [3:0]       exp_be;
  logic [31:0]      exp_wd;

  initial begin
    idle();
    m_be = {4'h3, 4'hF};
    m_wd = {32'h9ABC_DEF0, 32'h1234_5678};
    s_rd = '0;

    // reset state
    samp();
    chk("rst_valid", 64'(m_rdvalid), 64'h0);
    chk("rst_derr", 64'(derr), 64'h0);
    chk("rst_stall", 64'(m_stall), 64'h0);
    chk("rst_sre", 64'(s_re), 64'h0);
    step();
    rst_n = 1'b1;

    tbl[0] = '{30'h103, 1'b0, 1'b1, 30'h0, 1'b0, 1'b0, 4'b0000, 4'b0010, 30'h103, 4'hF, 32'h1234_5678, 2'b00};
    tbl[1] = '{30'h005, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 4'b0001, 4'b0000, 30'h005, 4'hF, 32'h1234_5678, 2'b00};
    tbl[2] = '{30'h0,   1'b0, 1'b0, 30'h2AA, 1'b1, 1'b0, 4'b0100, 4'b0000, 30'h2AA, 4'h3, 32'h9ABC_DEF0, 2'b00};
    tbl[3] = '{30'h3FF, 1'b0, 1'b1, 30'h010, 1'b1, 1'b0, 4'b0000, 4'b1000, 30'h3FF, 4'hF, 32'h1234_5678, 2'b10};
    tbl[4] = '{30'h201, 1'b1, 1'b1, 30'h0, 1'b0, 1'b0, 4'b0000, 4'b0100, 30'h201, 4'hF, 32'h1234_5678, 2'b00};
    tbl[5] = '{30'h0,   1'b0, 1'b0, 30'h700, 1'b0, 1'b1, 4'b0000, 4'b0000, 30'h700, 4'h3, 32'h9ABC_DEF0, 2'b00};
    tbl[6] = '{30'h0,   1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 4'b0000, 4'b0000, 30'h0, 4'h0, 32'h0, 2'b00};
    tbl[7] = '{30'h4FF, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 4'b0000, 4'b0000, 30'h4FF, 4'hF, 32'h1234_5678, 2'b00};

    for (int i = 0; i < 8; i++) begin
      step();
      pulse_reset();
      drive(0, tbl[i].a0, tbl[i].re0, tbl[i].we0);
      drive(1, tbl[i].a1, tbl[i].re1, tbl[i].we1);
      samp();
      chk($sformatf("tbl%0d_sre", i), 64'(s_re), 64'(tbl[i].sre));
      chk($sformatf("tbl%0d_swe", i), 64'(s_we), 64'(tbl[i].swe));
      chk($sformatf("tbl%0d_saddr", i), 64'(s_addr), 64'(tbl[i].saddr));
      chk($sformatf("tbl%0d_sbe", i), 64'(s_be), 64'(tbl[i].sbe));
      chk($sformatf("tbl%0d_swd", i), 64'(s_wd), 64'(tbl[i].swd));
      chk($sformatf("tbl%0d_stall", i), 64'(m_stall), 64'(tbl[i].stall));
    end

    // read return latency and lane routing
    step();
    pulse_reset();
    idle();
    drive(0, 30'h005, 1'b1, 1'b0);
    s_rd = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hA5A5_0001};
    samp();
    chk("rd_grant_valid", 64'(m_rdvalid), 64'h0);
    step();
    idle();
    samp();
    chk("rd_valid", 64'(m_rdvalid), 64'h1);
    chk("rd_data", m_rd, {32'h0, 32'hA5A5_0001});
    step();
    samp();
    chk("rd_valid_drop", 64'(m_rdvalid), 64'h0);

    // unmapped read by M1
    step();
    pulse_reset();
    drive(1, 30'h700, 1'b1, 1'b0);
    samp();
    chk("unmap_sre", 64'(s_re), 64'h0);
    step();
    idle();
    samp();
    chk("unmap_valid", 64'(m_rdvalid), 64'h2);
    chk("unmap_data", m_rd, {MISS, 32'h0});
    chk("unmap_derr", 64'(derr), 64'(DERR));
    step();
    samp();
    chk("unmap_derr_end", 64'(derr), 64'h0);

    // continuous contention alternates grants; stalled master keeps its request
    step();
    pulse_reset();
    drive(0, 30'h001, 1'b1, 1'b0);
    drive(1, 30'h102, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      samp();
      chk($sformatf("alt%0d_stall", c), 64'(m_stall), (c % 2 == 0) ? 64'h2 : 64'h1);
      chk($sformatf("alt%0d_sre", c), 64'(s_re), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0)
        chk($sformatf("alt%0d_valid", c), 64'(m_rdvalid), ((c - 1) % 2 == 0) ? 64'h1 : 64'h2);
      step();
    end

    // reset while a read return is pending
    pulse_reset();
    idle();
    drive(0, 30'h005, 1'b1, 1'b0);
    samp();
    chk("rstrd_sre", 64'(s_re), 64'h1);
    step();
    rst_n = 1'b0;
    idle();
    samp();
    chk("rstrd_valid", 64'(m_rdvalid), 64'h0);
    step();
    rst_n = 1'b1;
    samp();
    chk("rstrd_valid2", 64'(m_rdvalid), 64'h0);
    step();
    drive(0, 30'h001, 1'b1, 1'b0);
    drive(1, 30'h102, 1'b1, 1'b0);
    samp();
    chk("rstrd_first_gnt", 64'(m_stall), 64'h2);

    // randomized traffic against the reference model
    step();
    pulse_reset();
    idle();
    ptr = 0; pend = 0; pm = 0; ps = 0; pmiss = 0; derr_q = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) step();
      for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 7) == 0) a = 30'($urandom);
        else a = 30'(($urandom_range(0, 7) << AB) | $urandom_range(0, 255));
        drive(m, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      end
      m_be = 8'($urandom);
      m_wd = {$urandom, $urandom};
      for (int s = 0; s < NS; s++) s_rd[32*s +: 32] = $urandom;
      samp();

      req = m_re | m_we;
      gm = -1;
      for (int k = 0; k < NM; k++) begin
        idx = (ptr + k) % NM;
        if (gm < 0 && req[idx]) gm = idx;
      end
      gnt = '0;
      exp_sre = '0; exp_swe = '0;
      exp_addr = '0; exp_be = '0; exp_wd = '0;
      mapped = 1'b0;
      blk = 0;
      if (gm >= 0) begin
        gnt[gm] = 1'b1;
        exp_addr = m_addr[30*gm +: 30];
        exp_be = m_be[4*gm +: 4];
        exp_wd = m_wd[32*gm +: 32];
        blk = int'(exp_addr >> AB);
        mapped = (blk >= BASE) && (blk < BASE + NS);
        if (mapped) begin
          if (m_we[gm]) exp_swe[blk - BASE] = 1'b1;
          else exp_sre[blk - BASE] = 1'b1;
        end
      end
      exp_v = '0;
      exp_rd = '0;
      if (pend) begin
        exp_v[pm] = 1'b1;
        exp_rd[32*pm +: 32] = pmiss ? MISS : s_rd[32*ps +: 32];
      end

      chk("rnd_stall", 64'(m_stall), 64'(req & ~gnt));
      chk("rnd_sre", 64'(s_re), 64'(exp_sre));
      chk("rnd_swe", 64'(s_we), 64'(exp_swe));
      chk("rnd_saddr", 64'(s_addr), 64'(exp_addr));
      chk("rnd_sbe", 64'(s_be), 64'(exp_be));
      chk("rnd_swd", 64'(s_wd), 64'(exp_wd));
      chk("rnd_valid", 64'(m_rdvalid), 64'(exp_v));
      chk("rnd_rd", m_rd, exp_rd);
      chk("rnd_derr", 64'(derr), 64'(DERR && derr_q));

      derr_q = (gm >= 0) && !mapped;
      pend = (gm >= 0) && !m_we[gm];
      if (gm >= 0) begin
        ptr = (gm + 1) % NM;
        pm = gm;
        ps = blk - BASE;
        pmiss = !mapped;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbus_xbar.md
Name: dbus_xbar

Overview:
- Parametrised N-master / M-slave DBus interconnect; replaces the hard-wired shared DBus of the SoC top, where each slave decodes its own block and drives the read bus directly.
- Round-robin arbitration between masters; address-block decode; per-slave strobe gating; registered read-return routing.
- Sits between the CPU(s)/DMA masters and the DRAM/UART/peripheral slaves.

Parameters:
- NUM_MASTERS, 2, number of DBus masters (1..8).
- NUM_SLAVES, 4, number of DBus slaves (1..16).
- ADDR_BITS_PER_BLOCK, 8, word-address bits inside one slave block; block index = Addr[29:ADDR_BITS_PER_BLOCK].
- SLAVE_BASE_BLOCK, 0, block index of slave 0; slave s decodes block SLAVE_BASE_BLOCK+s.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_M_Addr  in  30*NUM_MASTERS  per-master word address; lane m = [30m+29:30m].
- i_M_Re  in  NUM_MASTERS  per-master read request.
- i_M_We  in  NUM_MASTERS  per-master write request.
- i_M_ByteEn  in  4*NUM_MASTERS  per-master byte enables.
- i_M_Wd  in  32*NUM_MASTERS  per-master write data.
- o_M_Stall  out  NUM_MASTERS  1 = request not accepted this cycle; master holds it.
- o_M_Rd  out  32*NUM_MASTERS  per-master read data.
- o_M_RdValid  out  NUM_MASTERS  1-cycle pulse: lane m of o_M_Rd valid.
- o_S_Addr  out  30  shared address to slaves (granted master's).
- o_S_Re  out  NUM_SLAVES  per-slave gated read strobe.
- o_S_We  out  NUM_SLAVES  per-slave gated write strobe.
- o_S_ByteEn  out  4  shared byte enables.
- o_S_Wd  out  32  shared write data.
- i_S_Rd  in  32*NUM_SLAVES  per-slave read data, valid one cycle after o_S_Re.
- o_DecodeErr  out  1  unmapped-access pulse (see Optional Feature).

Behaviour:
- Request: master m requests when i_M_Re[m] | i_M_We[m]; Re and We both high -> write only, Re ignored.
- Arbitration, combinational per cycle: among requesters, grant first index >= r_RrPtr, wrapping modulo NUM_MASTERS.
- r_RrPtr <= granted+1 (wrapping NUM_MASTERS-1 -> 0) on any grant; unchanged when idle.
- o_M_Stall[m] = request[m] & ~grant[m]; non-requesting masters see 0.
- Slave path, same cycle as grant (combinational): o_S_Addr/ByteEn/Wd = granted lane, else 0.
- o_S_Re/o_S_We: only the decoded slave's bit set. Out of range (block < SLAVE_BASE_BLOCK or >= SLAVE_BASE_BLOCK+NUM_SLAVES): no strobe asserted.
- Write latency: 0; completes in the grant cycle.
- Read tracking: on granted read, register r_RdPend=1, r_RdMst=m, r_RdSlv=s, r_RdMiss=unmapped.
- Read return, next cycle: o_M_RdValid[r_RdMst]=1; that lane = i_S_Rd lane r_RdSlv, or the miss value if r_RdMiss.
- Non-owning lanes of o_M_Rd = 0. Latency is exactly 1 cycle.
- Back-to-back: a new grant in the return cycle is allowed (read throughput 1/cycle).
- Reset (async assert, sync deassert use): r_RrPtr=0, r_RdPend=0, r_RdMst=0, r_RdSlv=0, r_RdMiss=0; o_M_RdValid=0, o_DecodeErr=0.
- Reset mid-read: the pending return is dropped (no RdValid).
- NUM_MASTERS=1: arbiter degenerates; Stall always 0.

Optional Feature:
- Macro DBUS_XBAR_DECODE_ERR_EN.
- Defined: unmapped read returns 32'hDEAD_BEEF. o_DecodeErr pulses 1 cycle, registered, the cycle after any granted unmapped read or write.
- Undefined: unmapped read returns 0; unmapped write silently dropped; o_DecodeErr tied 0; no extra flops.

Test Plan:
- Single master (M0) writes 0x1234_5678, ByteEn 4'hF, to block 1 offset 3 (SLAVE_BASE_BLOCK=0) -> same cycle: o_S_We=4'b0010, o_S_Addr=0x103, Stall=0.
- M0 reads block 0; slave0 returns 0xA5A5_0001 -> o_M_RdValid[0]=1 exactly 1 cycle later; lane0=0xA5A5_0001; lane1=0.
- M0 and M1 request continuously from reset -> grants alternate M0,M1,M0,M1; each stalled master holds its request; no strobe lost.
- M1 reads block 7 with NUM_SLAVES=4 and macro on -> no o_S_Re bit; next cycle lane1=0xDEAD_BEEF with RdValid; o_DecodeErr pulse.
- Same read with macro off -> lane1=0; o_DecodeErr=0.
- Granted read, then i_Rst_n low the following cycle -> o_M_RdValid stays 0; r_RrPtr=0; first post-reset grant goes to M0.
